updown_counter_n: RTL and testbench
===================================

UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter DIV_BITS, default 26: prescaler width; count step rate is clk/2^DIV_BITS; legal range 1..31.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 BTNR  input  1  reset, asynchronous, active-high.
REQ-006 BTNU  input  1  count-up request, level-sensitive, synchronous to clk.
REQ-007 BTND  input  1  count-down request, level-sensitive, synchronous to clk.
REQ-008 BTNL  input  1  load request, level-sensitive, synchronous to clk.
REQ-009 BTNC  input  1  run/pause toggle, rising-edge-sensitive, synchronous to clk.
REQ-010 load_val  input  WIDTH  value written to count on load.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 tick  output  1  one-clk strobe marking a count step opportunity.
REQ-013 at_max  output  1  high while count == 2^WIDTH-1 (combinational from count).
REQ-014 at_min  output  1  high while count == 0 (combinational from count).
REQ-015 wrap  output  1  registered one-clk pulse on a limit wrap.
REQ-016 dir  output  1  registered; 1 = last step was up, 0 = last step was down.
REQ-017 running  output  1  registered; 1 = counting enabled, 0 = paused.

Function
REQ-018 Prescaler: DIV_BITS-bit register that increments by 1 each clk while running=1, wraps to 0, and holds while running=0.
REQ-019 tick = running AND prescaler all-ones; count steps only on clk edges where tick=1.
REQ-020 Per-edge priority: BTNL first, then BTNU and BTND together, then BTNU alone, then BTND alone, then idle.
REQ-021 BTNL=1: count <= load_val on that edge regardless of tick or running; prescaler <= 0; dir and wrap unchanged except wrap <= 0.
REQ-022 BTNU=1 and BTND=1 with tick, no BTNL: count and dir hold.
REQ-023 BTNU=1 with tick: count <= count+1 modulo 2^WIDTH, dir <= 1.
REQ-024 BTND=1 with tick: count <= count-1 modulo 2^WIDTH, dir <= 0.
REQ-025 SATURATE=0, up step from 2^WIDTH-1 to 0, or down step from 0 to 2^WIDTH-1: wrap <= 1 for exactly that edge.
REQ-026 SATURATE=1: an up step at max or a down step at 0 holds count; dir still updates; wrap stays 0.
REQ-027 wrap is 0 on every edge that does not perform a wrapping step.
REQ-028 BTNC edge detection: a registered copy btnc_q of BTNC; a rising edge is BTNC=1 and btnc_q=0; it toggles running on that edge; holding BTNC high toggles once.
REQ-029 Pause: running=0 freezes prescaler and suppresses tick; BTNL still loads.
REQ-030 A BTNC rising edge coincident with tick: the step on that edge completes using the pre-toggle tick, then running toggles.

Reset
REQ-031 BTNR=1 asynchronously forces count=0, prescaler=0, running=1, dir=1, wrap=0, btnc_q=0; outputs take these values without waiting for clk.
REQ-032 Reset asserted mid-count abandons any pending step; first tick after deassertion occurs on the 2^DIV_BITS-th clk edge.
REQ-033 All other inputs are ignored while BTNR=1.

Verification (WIDTH=8, DIV_BITS=1, SATURATE=0 unless stated)
REQ-034 Load then up: BTNL=1 with load_val=0xAA for one edge, then BTNU=1 -> count=0xAA, then 0xAB after 2 clks, 0xAC after 4 clks; tick every 2nd clk; dir=1.
REQ-035 Wrap: load 0xFE, hold BTNU -> 0xFF, then 0x00 with wrap=1 for one clk only, at_max then at_min asserted; load 0x00 and hold BTND -> 0xFF with wrap pulse, dir=0.
REQ-036 Saturate: with SATURATE=1, load 0xFF and hold BTNU for 6 clks -> count stays 0xFF, wrap never 1; load 0x00 and hold BTND -> stays 0x00.
REQ-037 Priority: BTNL=1, BTNU=1, BTND=1 together with load_val=0x55 -> count=0x55; drop BTNL -> count holds at 0x55 for 8 clks.
REQ-038 Pause: count at 0x10, hold BTNU, pulse BTNC high for 3 clks -> running=0, count frozen at current value, tick=0; next BTNC rising edge -> running=1 and counting resumes.
REQ-039 Async reset: count 0x37 mid-up-count, assert BTNR between clk edges -> count=0x00, running=1, dir=1 immediately; release -> first increment 2 clks later.

Source files
------------

// File: rtl/updown_counter_n.sv
// Prescaled up/down counter with synchronous load, run/pause toggle and a
// choice of wrap-around or saturating behaviour at the count limits.
module updown_counter_n #(
   parameter int WIDTH    = 8,
   parameter int DIV_BITS = 26,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             BTNR,
   input  logic             BTNU,
   input  logic             BTND,
   input  logic             BTNL,
   input  logic             BTNC,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap,
   output logic             dir,
   output logic             running
);

   localparam bit HOLD_AT_LIMIT = (SATURATE != 0);

   logic [WIDTH-1:0]    count_reg;
   logic [WIDTH-1:0]    count_next;
   logic [DIV_BITS-1:0] prescaler_reg;
   logic [DIV_BITS-1:0] prescaler_next;
   logic                running_reg;
   logic                running_next;
   logic                dir_reg;
   logic                dir_next;
   logic                wrap_reg;
   logic                wrap_next;
   logic                btnc_q_reg;
   logic                btnc_rise;
   logic                step_up;
   logic                step_down;

   assign tick      = running_reg & (&prescaler_reg);
   assign at_max    = &count_reg;
   assign at_min    = ~|count_reg;
   assign btnc_rise = BTNC & ~btnc_q_reg;

   // Pressing both directions at once cancels the step entirely.
   assign step_up   = tick & BTNU & ~BTND;
   assign step_down = tick & BTND & ~BTNU;

   always_comb begin
      count_next     = count_reg;
      dir_next       = dir_reg;
      wrap_next      = 1'b0;
      prescaler_next = running_reg ? prescaler_reg + DIV_BITS'(1) : prescaler_reg;
      running_next   = running_reg ^ btnc_rise;

      if (BTNL) begin
         count_next     = load_val;
         prescaler_next = '0;
      end else if (step_up) begin
         dir_next = 1'b1;
         if (!(at_max && HOLD_AT_LIMIT)) begin
            count_next = count_reg + WIDTH'(1);
            wrap_next  = at_max;
         end
      end else if (step_down) begin
         dir_next = 1'b0;
         if (!(at_min && HOLD_AT_LIMIT)) begin
            count_next = count_reg - WIDTH'(1);
            wrap_next  = at_min;
         end
      end
   end

   // The step above uses the pre-toggle tick; running only changes afterwards.
   always_ff @(posedge clk or posedge BTNR) begin
      if (BTNR) begin
         count_reg     <= '0;
         prescaler_reg <= '0;
         running_reg   <= 1'b1;
         dir_reg       <= 1'b1;
         wrap_reg      <= 1'b0;
         btnc_q_reg    <= 1'b0;
      end else begin
         count_reg     <= count_next;
         prescaler_reg <= prescaler_next;
         running_reg   <= running_next;
         dir_reg       <= dir_next;
         wrap_reg      <= wrap_next;
         btnc_q_reg    <= BTNC;
      end
   end

   assign count   = count_reg;
   assign wrap    = wrap_reg;
   assign dir     = dir_reg;
   assign running = running_reg;

endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench: a wrapping and a saturating counter share random and
// directed stimulus; an arithmetic model predicts each edge's outcome.
`timescale 1ns/1ps
module tb_updown_counter_n;

   localparam int PER  = 2;     // 2**DIV_BITS with DIV_BITS = 1
   localparam int CMAX = 255;   // 2**WIDTH - 1 with WIDTH = 8

   logic       clk = 1'b0;
   logic       BTNR, BTNU, BTND, BTNL, BTNC;
   logic [7:0] load_val;

   logic [7:0] c0, c1;
   logic       t0, amx0, amn0, w0, d0, r0;
   logic       t1, amx1, amn1, w1, d1, r1;

   always #5 clk = ~clk;

   updown_counter_n #(.WIDTH(8), .DIV_BITS(1), .SATURATE(0)) u_wrap (
      .clk(clk), .BTNR(BTNR), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNC(BTNC),
      .load_val(load_val), .count(c0), .tick(t0), .at_max(amx0), .at_min(amn0),
      .wrap(w0), .dir(d0), .running(r0));

   updown_counter_n #(.WIDTH(8), .DIV_BITS(1), .SATURATE(1)) u_sat (
      .clk(clk), .BTNR(BTNR), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNC(BTNC),
      .load_val(load_val), .count(c1), .tick(t1), .at_max(amx1), .at_min(amn1),
      .wrap(w1), .dir(d1), .running(r1));

   typedef struct {
      int count;
      int phase;     // clocks elapsed modulo PER since last prescaler clear
      bit running;
      bit dir;
      bit wrap;
      bit prev_c;
   } mstate_t;

   typedef struct {
      int count;
      bit tick;
      bit wrap;
      bit dir;
      bit running;
   } obs_t;

   mstate_t m_wrap, m_sat;
   obs_t    q_wrap[$];
   obs_t    q_sat[$];
   int      n_pass  = 0;
   int      n_total = 0;

   function automatic mstate_t reset_state();
      mstate_t s;
      s.count = 0; s.phase = 0; s.running = 1'b1;
      s.dir = 1'b1; s.wrap = 1'b0; s.prev_c = 1'b0;
      return s;
   endfunction

   function automatic mstate_t model_step(mstate_t s, bit u, bit d, bit l, bit c, int lv, bit sat);
      mstate_t n;
      bit      tk;
      int      target;
      n  = s;
      tk = s.running && (s.phase == PER - 1);
      n.wrap = 1'b0;
      if (l) begin
         n.count = lv;
         n.phase = 0;
      end else begin
         if (s.running) n.phase = (s.phase + 1) % PER;
         if (tk && (u != d)) begin
            target = u ? s.count + 1 : s.count - 1;
            n.dir  = u;
            if (target > CMAX || target < 0) begin
               if (!sat) begin
                  n.count = (target + CMAX + 1) % (CMAX + 1);
                  n.wrap  = 1'b1;
               end
            end else begin
               n.count = target;
            end
         end
      end
      if (c && !s.prev_c) n.running = !s.running;
      n.prev_c = c;
      return n;
   endfunction

   function automatic obs_t observe(mstate_t s);
      obs_t o;
      o.count   = s.count;
      o.tick    = s.running && (s.phase == PER - 1);
      o.wrap    = s.wrap;
      o.dir     = s.dir;
      o.running = s.running;
      return o;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic compare(input string tag, input obs_t e, input logic [7:0] c, input logic t,
                          input logic w, input logic d, input logic r,
                          input logic amx, input logic amn);
      check({tag, "_count"},   int'(c),   e.count);
      check({tag, "_tick"},    int'(t),   int'(e.tick));
      check({tag, "_wrap"},    int'(w),   int'(e.wrap));
      check({tag, "_dir"},     int'(d),   int'(e.dir));
      check({tag, "_running"}, int'(r),   int'(e.running));
      check({tag, "_at_max"},  int'(amx), int'(e.count == CMAX));
      check({tag, "_at_min"},  int'(amn), int'(e.count == 0));
   endtask

   // Monitor: one popped expectation per DUT per clock edge.
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_wrap.size() > 0) begin
            e = q_wrap.pop_front();
            compare("wrap", e, c0, t0, w0, d0, r0, amx0, amn0);
         end
         if (q_sat.size() > 0) begin
            e = q_sat.pop_front();
            compare("sat", e, c1, t1, w1, d1, r1, amx1, amn1);
         end
      end
   end

   task automatic cycle(input bit u, input bit d, input bit l, input bit c, input logic [7:0] lv);
      @(negedge clk);
      BTNR = 1'b0; BTNU = u; BTND = d; BTNL = l; BTNC = c; load_val = lv;
      m_wrap = model_step(m_wrap, u, d, l, c, int'(lv), 1'b0);
      m_sat  = model_step(m_sat,  u, d, l, c, int'(lv), 1'b1);
      q_wrap.push_back(observe(m_wrap));
      q_sat.push_back(observe(m_sat));
      $display("cycle t=%0t U=%0b D=%0b L=%0b C=%0b lv=%02h -> exp wrap_cnt=%02h sat_cnt=%02h",
               $time, u, d, l, c, lv, m_wrap.count, m_sat.count);
      @(posedge clk);
      #2;
   endtask

   // Reset asserted between edges must take effect before the next edge.
   task automatic reset_pulse();
      @(negedge clk);
      #2 BTNR = 1'b1;
      #1;
      check("rst_async_count", int'(c0), 0);
      check("rst_async_running", int'(r0), 1);
      check("rst_async_dir", int'(d0), 1);
      check("rst_async_wrap", int'(w0), 0);
      check("rst_async_sat_count", int'(c1), 0);
      check("rst_async_sat_running", int'(r1), 1);
      m_wrap = reset_state();
      m_sat  = reset_state();
      q_wrap.push_back(observe(m_wrap));
      q_sat.push_back(observe(m_sat));
      $display("reset t=%0t async assert, state cleared", $time);
      @(posedge clk);
      #2;
   endtask

   initial begin
      int         r;
      bit         u, d, l, btnc_lvl;
      logic [7:0] lv;

      BTNR = 1'b1; BTNU = 1'b0; BTND = 1'b0; BTNL = 1'b0; BTNC = 1'b0; load_val = 8'h00;
      #1;
      check("reset_count", int'(c0), 0);
      check("reset_running", int'(r0), 1);
      check("reset_dir", int'(d0), 1);
      check("reset_wrap", int'(w0), 0);
      check("reset_tick", int'(t0), 0);
      m_wrap = reset_state();
      m_sat  = reset_state();

      // Load then count up
      cycle(0, 0, 1, 0, 8'hAA);
      check("load_aa", int'(c0), 8'hAA);
      repeat (2) cycle(1, 0, 0, 0, 8'h00);
      check("up_ab", int'(c0), 8'hAB);
      repeat (2) cycle(1, 0, 0, 0, 8'h00);
      check("up_ac", int'(c0), 8'hAC);
      check("up_dir", int'(d0), 1);

      // Wrap at the top, then at the bottom
      cycle(0, 0, 1, 0, 8'hFE);
      repeat (2) cycle(1, 0, 0, 0, 8'h00);
      check("wrap_ff", int'(c0), 8'hFF);
      check("wrap_at_max", int'(amx0), 1);
      repeat (2) cycle(1, 0, 0, 0, 8'h00);
      check("wrap_00", int'(c0), 8'h00);
      check("wrap_pulse_up", int'(w0), 1);
      check("wrap_at_min", int'(amn0), 1);
      cycle(1, 0, 0, 0, 8'h00);
      check("wrap_pulse_ends", int'(w0), 0);
      cycle(0, 0, 1, 0, 8'h00);
      repeat (2) cycle(0, 1, 0, 0, 8'h00);
      check("wrap_down_ff", int'(c0), 8'hFF);
      check("wrap_pulse_down", int'(w0), 1);
      check("wrap_down_dir", int'(d0), 0);

      // Saturation on the second instance
      cycle(0, 0, 1, 0, 8'hFF);
      repeat (6) cycle(1, 0, 0, 0, 8'h00);
      check("sat_hold_ff", int'(c1), 8'hFF);
      check("sat_no_wrap", int'(w1), 0);
      cycle(0, 0, 1, 0, 8'h00);
      repeat (6) cycle(0, 1, 0, 0, 8'h00);
      check("sat_hold_00", int'(c1), 8'h00);
      check("sat_down_dir", int'(d1), 0);

      // Priority: load beats both directions; both directions cancel
      cycle(1, 1, 1, 0, 8'h55);
      check("prio_load", int'(c0), 8'h55);
      repeat (8) cycle(1, 1, 0, 0, 8'h00);
      check("prio_hold", int'(c0), 8'h55);

      // Pause: the BTNC edge coincides with a tick, so one last step lands
      cycle(0, 0, 1, 0, 8'h10);
      repeat (3) cycle(1, 0, 0, 0, 8'h00);
      repeat (3) cycle(1, 0, 0, 1, 8'h00);
      check("pause_running", int'(r0), 0);
      check("pause_tick", int'(t0), 0);
      check("pause_count", int'(c0), 8'h12);
      repeat (4) cycle(1, 0, 0, 0, 8'h00);
      check("pause_frozen", int'(c0), 8'h12);
      cycle(1, 0, 0, 1, 8'h00);
      check("resume_running", int'(r0), 1);
      repeat (2) cycle(1, 0, 0, 0, 8'h00);
      check("resume_count", int'(c0), 8'h13);

      // Asynchronous reset mid-count
      cycle(0, 0, 1, 0, 8'h37);
      cycle(1, 0, 0, 0, 8'h00);
      reset_pulse();
      cycle(1, 0, 0, 0, 8'h00);
      check("post_rst_first", int'(c0), 8'h00);
      cycle(1, 0, 0, 0, 8'h00);
      check("post_rst_second", int'(c0), 8'h01);

      // Randomised traffic biased toward the count limits
      btnc_lvl = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            reset_pulse();
         end else begin
            u = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 40);
            l = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 10) btnc_lvl = ~btnc_lvl;
            case ($urandom_range(0, 4))
               0:       lv = 8'h00;
               1:       lv = 8'h01;
               2:       lv = 8'hFE;
               3:       lv = 8'hFF;
               default: lv = 8'($urandom);
            endcase
            cycle(u, d, l, btnc_lvl, lv);
         end
      end

      check("queue_drained", q_wrap.size() + q_sat.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
